// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: requester count,
// FSM state type and the one-hot grant encoder.
package arb_pkg;

    localparam int ARB_N = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [ARB_N-1:0] onehot4(input logic [1:0] idx);
        logic [ARB_N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Circular priority picker: finds the first set request bit at or after
// ptr, wrapping from 3 back to 0. Purely combinational.
module rr_pick
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0] req,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       idx
);

    logic [1:0] cand;
    logic       found;

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        any   = |req;
        idx   = ptr;
        cand  = ptr;
        found = 1'b0;
        // 2-bit addition wraps modulo 4, which gives the circular scan.
        for (int k = 0; k < ARB_N; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered zero/one-hot grant,
// a bounded hold time and a single-cycle timeout pulse on forced release.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic         timeout
);

    localparam int            HW         = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

    arb_state_t    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    hidx_q, hidx_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;

    logic          pick_any;
    logic [1:0]    pick_idx;
    logic          rel_voluntary;
    logic          rel_limit;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // A holder that signals done or drops its request outranks the hold
    // limit, so the timeout pulse only marks a genuinely forced release.
    assign rel_voluntary = done | ~req[hidx_q];
    assign rel_limit     = (hcnt_q == HOLD_LIMIT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hidx_d      = hidx_q;
        hcnt_d      = hcnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    hidx_d      = pick_idx;
                    hcnt_d      = HW'(1);
                    gnt_d       = onehot4(pick_idx);
                    gnt_valid_d = 1'b1;
                end else begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end
            end

            GRANT: begin
                if (rel_voluntary || rel_limit) begin
                    // Releasing always passes through one idle cycle, so the
                    // grant vector never switches directly between holders.
                    state_d     = IDLE;
                    ptr_d       = hidx_q + 2'd1;
                    hcnt_d      = '0;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = rel_limit & ~rel_voluntary;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            hidx_q      <= 2'd0;
            hcnt_q      <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hidx_q      <= hidx_d;
            hcnt_q      <= hcnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4 (MAX_HOLD=4): directed scenarios plus
// a long random run compared against a behavioural arbitration model.
module tb_rr_arbiter4;

    localparam int MAXH     = 4;
    localparam int WAIT_MAX = 4 * (MAXH + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Behavioural model: holder index (-1 = nobody), priority pointer,
    // cycles held so far, and the expected timeout output.
    int m_holder;
    int m_ptr;
    int m_cnt;
    bit m_tmo;

    int wait_cnt [4];
    int max_wait;

    rr_arbiter4 #(.N(4), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_gnt();
        logic [3:0] e;
        e = 4'b0000;
        if (m_holder >= 0) e[m_holder] = 1'b1;
        return e;
    endfunction

    // Downstream one-hot-to-binary decoder error flag: not exactly one bit set.
    function automatic bit dec_err(input logic [3:0] g);
        int ones;
        ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(g[i]);
        return ones != 1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic d);
        m_tmo = 1'b0;
        if (m_holder < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_holder < 0 && r[(m_ptr + k) % 4]) begin
                    m_holder = (m_ptr + k) % 4;
                    m_cnt    = 1;
                end
            end
        end else if (d || !r[m_holder] || m_cnt == MAXH) begin
            m_tmo    = !(d || !r[m_holder]);
            m_ptr    = (m_holder + 1) % 4;
            m_holder = -1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_ptr    = 0;
        m_cnt    = 0;
        m_tmo    = 1'b0;
    endtask

    // Apply inputs, advance one edge, then compare all outputs to the model.
    task automatic cycle(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check("gnt", 32'(gnt), 32'(model_gnt()));
        check("gnt_valid", 32'(gnt_valid), 32'(m_holder >= 0));
        check("timeout", 32'(timeout), 32'(m_tmo));
    endtask

    task automatic do_reset();
        req  = 4'b0000;
        done = 1'b0;
        rst  = 1'b1;
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    logic [3:0] fair_seq [9];
    logic [3:0] r_rand;
    logic       d_rand;

    initial begin
        rst  = 1'b0;
        req  = 4'b0000;
        done = 1'b0;
        #1;
        do_reset();

        // Reset in the middle of a grant to requester 2.
        cycle(4'b0100, 1'b0);
        check("pre_rst_gnt", 32'(gnt), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_valid", 32'(gnt_valid), 32'h0);
        check("async_rst_tmo", 32'(timeout), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(4'b1111, 1'b0);
        check("post_rst_gnt", 32'(gnt), 32'h1);

        // Fairness: all requesting, done asserted throughout.
        do_reset();
        fair_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                     4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 9; i++) begin
            cycle(4'b1111, 1'b1);
            check($sformatf("fair_%0d", i), 32'(gnt), 32'(fair_seq[i]));
        end

        // Wrap-around of the priority pointer.
        do_reset();
        cycle(4'b1000, 1'b0); check("wrap_a", 32'(gnt), 32'h8);
        cycle(4'b1000, 1'b1); check("wrap_a_rel", 32'(gnt), 32'h0);
        cycle(4'b0001, 1'b0); check("wrap_b", 32'(gnt), 32'h1);
        cycle(4'b0001, 1'b1);
        cycle(4'b1001, 1'b0); check("wrap_c", 32'(gnt), 32'h8);
        cycle(4'b1001, 1'b1);
        cycle(4'b0101, 1'b0); check("wrap_d", 32'(gnt), 32'h1);
        cycle(4'b0101, 1'b1);
        cycle(4'b0100, 1'b0); check("wrap_e", 32'(gnt), 32'h4);
        cycle(4'b0100, 1'b1);
        cycle(4'b0001, 1'b0); check("wrap_ptr3", 32'(gnt), 32'h1);

        // Forced release after MAX_HOLD cycles.
        do_reset();
        for (int i = 0; i < MAXH; i++) begin
            cycle(4'b0010, 1'b0);
            check($sformatf("hold_%0d", i), 32'(gnt), 32'h2);
            check($sformatf("hold_tmo_%0d", i), 32'(timeout), 32'h0);
        end
        cycle(4'b0010, 1'b0);
        check("tmo_drop_gnt", 32'(gnt), 32'h0);
        check("tmo_pulse", 32'(timeout), 32'h1);
        cycle(4'b0010, 1'b0);
        check("tmo_regrant", 32'(gnt), 32'h2);
        check("tmo_cleared", 32'(timeout), 32'h0);

        // done coincides with the hold limit: no timeout.
        do_reset();
        for (int i = 0; i < MAXH; i++) cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b1);
        check("sim_done_gnt", 32'(gnt), 32'h0);
        check("sim_done_tmo", 32'(timeout), 32'h0);

        // Request dropped at the hold limit: no timeout.
        do_reset();
        for (int i = 0; i < MAXH; i++) cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        check("sim_drop_gnt", 32'(gnt), 32'h0);
        check("sim_drop_tmo", 32'(timeout), 32'h0);

        // Request dropped during the second cycle of a grant.
        do_reset();
        cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        check("drop2_gnt", 32'(gnt), 32'h0);
        check("drop2_tmo", 32'(timeout), 32'h0);

        // Random run with invariant and starvation tracking.
        do_reset();
        r_rand   = 4'b0000;
        max_wait = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 20000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(7) == 0) r_rand[i] = ~r_rand[i];
            d_rand = ($urandom_range(5) == 0);
            cycle(r_rand, d_rand);
            check("onehot0", 32'($onehot0(gnt)), 32'h1);
            check("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
            check("dec_err", 32'(dec_err(gnt)), 32'(!gnt_valid));
            for (int i = 0; i < 4; i++) begin
                if (r_rand[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
        check("starvation_bound", 32'(max_wait <= WAIT_MAX), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arbiter4

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that issues a registered one-hot grant vector. It sits directly upstream of the one-hot-to-binary decoder and drives the decoder's 4-bit input. The grant is guaranteed to be zero-hot or one-hot, never multi-hot. The decoder's error flag is therefore asserted only during the defined idle cycles.

## Interface
- `N`, 4, number of requesters; fixed at 4 to match the decoder width.
- `MAX_HOLD`, 16, maximum consecutive cycles a grant may be held before a forced release. Legal range is 2 to 255.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  request lines; bit i is requester i; level-sensitive.
- `done`  in  1  holder releases its grant; sampled only in GRANT.
- `gnt`  out  4  registered one-hot grant, or 4'b0000 when no grant is active.
- `gnt_valid`  out  1  registered; equals |gnt.
- `timeout`  out  1  registered single-cycle pulse on a forced release.

## Operation
- State machine with two states, IDLE and GRANT. Internal state: 2-bit `ptr` (next-priority index) and hold counter `hcnt` of width $clog2(MAX_HOLD+1).
- IDLE behaviour:
  - If `req` != 0, select the first set bit scanning circularly from `ptr` upward: ptr, ptr+1, … mod 4.
  - Next cycle: `gnt` = onehot(selected), `gnt_valid`=1, `hcnt`=1, state=GRANT.
  - If `req` == 0, remain in IDLE with `gnt`=0.
- GRANT behaviour, with holder index h:
  - Release if any of the following holds: `done`=1, `req[h]`=0, or `hcnt`==MAX_HOLD.
  - On release, next cycle: `gnt`=0, `gnt_valid`=0, `ptr`=(h+1) mod 4, state=IDLE.
  - Otherwise `gnt` is unchanged and `hcnt` increments.
- `timeout`=1 on the release edge only when the release cause is `hcnt`==MAX_HOLD and both `done`=0 and `req[h]`=1. In every other cycle `timeout`=0.
- Simultaneous release causes: `done` or a dropped `req[h]` takes priority, so no `timeout` pulse is issued.
- After any release, one IDLE cycle with `gnt`=0000 always follows; there are no back-to-back grants. The downstream decoder reports err=1 for that cycle by design.
- A requester that still holds `req` high after release competes normally. Because `ptr` has advanced, it has lowest priority and cannot starve the others.
- `done` and `req` changes in IDLE do not affect `ptr`.
- `ptr` wraps from 3 to 0, and the circular scan handles wrap (e.g. ptr=3, req=0001 → grant 0001).

## Timing
- Reset values, applied immediately on `rst` assertion regardless of clock:
  - `gnt`=0000, `gnt_valid`=0, `timeout`=0.
  - `ptr`=0, `hcnt`=0, state=IDLE.
- Reset mid-grant drops `gnt` asynchronously, with no `timeout` pulse. After reset deassertion, arbitration restarts from `ptr`=0.
- Latency:
  - `req` sampled at edge k → `gnt` valid after edge k (1 cycle).
  - Release condition sampled at edge k → `gnt`=0 after edge k.
  - Earliest next grant is after edge k+1.
- A grant lasts between 1 and MAX_HOLD cycles. `hcnt` never exceeds MAX_HOLD.
- All outputs are flop outputs, with no combinational path from `req` or `done` to outputs.

## Structure
- Shared package `arb_pkg`:
  - constant `ARB_N`=4.
  - typedef `arb_state_t` enum {IDLE, GRANT}.
  - function `onehot4(idx)`.
- One sub-module, `rr_pick`: purely combinational.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `any`, `idx[1:0]` (first set bit at or after ptr, circularly).
  - `rr_arbiter4` instantiates it once and holds all registers.

## Test plan
- Reset: assert `rst` mid-GRANT with gnt=0100 → `gnt`=0000, `gnt_valid`=0 immediately; after release, req=1111 → gnt=0001.
- Round-robin fairness: req=1111 held, `done` pulsed in every grant cycle → gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Wrap: after a grant to 1000 (ptr=0), then req=0001 → 0001; after that grant, req=1001 → 1000; after that, req=0101 → 0001.
- Timeout (MAX_HOLD=4): req=0010 held, done=0 → gnt=0010 for exactly 4 cycles, `timeout`=1 on the cycle gnt drops, then 0000 one cycle, then 0010 again.
- Simultaneous causes (MAX_HOLD=4): `done`=1 on the 4th cycle of a grant → release with `timeout`=0; `req[h]` dropped on the 2nd cycle → gnt=0000 next cycle, no timeout.
- Invariant checks throughout a 20000-cycle random run with the decoder attached:
  - $onehot0(gnt) holds every cycle.
  - gnt_valid == |gnt.
  - The decoder's err output equals !gnt_valid.
  - No requester with continuous req waits more than 4·(MAX_HOLD+1) cycles.
